spi_tx_sched: RTL and testbench

Transmit-side scheduler for the SPI serial path. It shares one SPI master output (sclk/mosi) between four transmit FIFOs using round-robin arbitration. For each granted channel it pops one word, asserts that channel's chip select, and shifts the word out MSB first in SPI mode 0. It sits between the per-channel TX FIFOs and the SPI pads, and owns all SCLK generation and frame sequencing.

---
 rtl/spi_tx_sched_if.sv | 25 ++
 rtl/spi_tx_sched.sv | 106 ++++++++++
 tb/tb_spi_tx_sched.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_tx_sched_if.sv
// spi_tx_sched_if: FIFO-side and SPI pad-side signals of the TX scheduler.
interface spi_tx_sched_if #(
  parameter int DATAWIDTH = 8
);
  logic                 enable;
  logic [3:0]           not_empty;
  logic [DATAWIDTH-1:0] rdata0;
  logic [DATAWIDTH-1:0] rdata1;
  logic [DATAWIDTH-1:0] rdata2;
  logic [DATAWIDTH-1:0] rdata3;
  logic [3:0]           ren;
  logic [3:0]           cs_n;
  logic                 sclk;
  logic                 mosi;
  logic                 busy;
  logic [1:0]           ch_sel;
  modport master (
    input  enable, not_empty, rdata0, rdata1, rdata2, rdata3,
    output ren, cs_n, sclk, mosi, busy, ch_sel
  );
  modport slave (
    output enable, not_empty, rdata0, rdata1, rdata2, rdata3,
    input  ren, cs_n, sclk, mosi, busy, ch_sel
  );
endinterface

// File: rtl/spi_tx_sched.sv
// spi_tx_sched: round-robin scheduler sharing one SPI mode-0 master between four TX FIFOs.
module spi_tx_sched #(
  parameter int DATAWIDTH = 8,
  parameter int DIV       = 2,
  parameter int GAP       = 2
) (
  input logic            clk,
  input logic            rstn,
  spi_tx_sched_if.master bus
);
  localparam int BW = $clog2(DATAWIDTH + 1);
  typedef enum logic [2:0] {S_IDLE, S_ARB, S_READ, S_LOAD, S_SHIFT, S_GAP} state_t;
  state_t               state;
  state_t               state_n;
  logic [1:0]           last;
  logic [1:0]           grant;
  logic                 found;
  logic                 req;
  logic                 half_done;
  logic                 last_bit;
  logic                 gap_done;
  logic                 frame_done;
  logic [7:0]           dcnt;
  logic [7:0]           gcnt;
  logic [BW-1:0]        bcnt;
  logic [DATAWIDTH-1:0] shreg;
  logic [DATAWIDTH-1:0] rsel;
  assign req        = bus.enable && |bus.not_empty;
  assign half_done  = dcnt == 8'(DIV - 1);
  assign last_bit   = bcnt == BW'(DATAWIDTH - 1);
  assign gap_done   = gcnt == 8'(GAP - 1);
  assign frame_done = half_done && bus.sclk && last_bit;
  assign rsel = bus.ch_sel == 2'd0 ? bus.rdata0 :
                bus.ch_sel == 2'd1 ? bus.rdata1 :
                bus.ch_sel == 2'd2 ? bus.rdata2 : bus.rdata3;
  // Scan downward so the channel closest after last wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 3; i >= 0; i--)
      if (bus.not_empty[last + 2'(i + 1)]) begin
        grant = last + 2'(i + 1);
        found = 1'b1;
      end
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= S_IDLE;
    else       state <= state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  state_n = req ? S_ARB : S_IDLE;
      S_ARB:   state_n = found ? S_READ : S_IDLE;
      S_READ:  state_n = S_LOAD;
      S_LOAD:  state_n = S_SHIFT;
      S_SHIFT: state_n = frame_done ? S_GAP : S_SHIFT;
      S_GAP:   state_n = gap_done ? (req ? S_ARB : S_IDLE) : S_GAP;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      bus.ren    <= '0;
      bus.cs_n   <= 4'hF;
      bus.sclk   <= 1'b0;
      bus.mosi   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.ch_sel <= '0;
      last       <= 2'd3;
      shreg      <= '0;
      dcnt       <= '0;
      bcnt       <= '0;
      gcnt       <= '0;
    end else begin
      bus.ren  <= '0;
      bus.busy <= state_n != S_IDLE;
      if (state == S_ARB && found) begin
        bus.ch_sel <= grant;
        last       <= grant;
        bus.ren    <= 4'b0001 << grant;
      end
      if (state == S_LOAD) begin
        shreg    <= rsel;
        bus.mosi <= rsel[DATAWIDTH-1];
        bus.cs_n <= ~(4'b0001 << bus.ch_sel);
        bus.sclk <= 1'b0;
        dcnt     <= '0;
        bcnt     <= '0;
      end
      if (state == S_SHIFT) begin
        dcnt <= half_done ? '0 : dcnt + 8'd1;
        if (half_done) bus.sclk <= ~bus.sclk;
        // Falling edge: advance to the next bit, or close the frame after the last one.
        if (half_done && bus.sclk) begin
          shreg    <= shreg << 1;
          bus.mosi <= last_bit ? 1'b0 : shreg[DATAWIDTH-2];
          bcnt     <= bcnt + BW'(1);
          if (last_bit) begin
            bus.cs_n <= 4'hF;
            gcnt     <= '0;
          end
        end
      end
      if (state == S_GAP) gcnt <= gcnt + 8'd1;
    end
endmodule

// File: tb/tb_spi_tx_sched.sv
// tb_spi_tx_sched: scenario tasks plus a frame monitor that checks each SPI frame against a scoreboard.
module tb_spi_tx_sched;
  typedef struct packed {logic [1:0] ch; logic [7:0] data;} exp_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  spi_tx_sched_if #(.DATAWIDTH(8)) ifa ();
  spi_tx_sched_if #(.DATAWIDTH(8)) ifb ();
  spi_tx_sched #(.DATAWIDTH(8), .DIV(2), .GAP(2)) dut_a (.clk(clk), .rstn(rstn), .bus(ifa.master));
  spi_tx_sched #(.DATAWIDTH(8), .DIV(1), .GAP(2)) dut_b (.clk(clk), .rstn(rstn), .bus(ifb.master));
  int         checks = 0;
  int         errors = 0;
  int         ren_cnt = 0;
  int         frames = 0;
  int         gap_cnt = 0;
  int         low_cnt = 0;
  int         nbits = 0;
  logic [3:0] ren_hist = '0;
  logic [3:0] fr_cs = '1;
  logic [7:0] word = '0;
  bit         in_frame = 0;
  bit         prev_end = 0;
  bit         prev_sclk = 0;
  exp_t       sb[$];
  int         gaps[$];
  exp_t       mon_e;
  // Frame monitor for the DIV=2 instance: every frame is 8 bits, 32 cycles of cs_n low.
  always @(negedge clk) begin
    if (!rstn) begin
      in_frame  = 0;
      prev_end  = 0;
      prev_sclk = 0;
    end else begin
      if (|ifa.ren) begin
        ren_cnt++;
        ren_hist = ren_hist | ifa.ren;
      end
      if (!in_frame && ifa.cs_n != 4'hF) begin
        in_frame = 1;
        low_cnt  = 0;
        nbits    = 0;
        word     = '0;
        fr_cs    = ifa.cs_n;
        if (prev_end) gaps.push_back(gap_cnt);
      end
      if (in_frame) begin
        if (ifa.cs_n == 4'hF) begin
          in_frame = 0;
          prev_end = 1;
          gap_cnt  = 1;
          frames++;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame: cs_n=%b word=%h, no frame expected", fr_cs, word);
          end else begin
            mon_e = sb.pop_front();
            checks += 4;
            if (fr_cs !== ~(4'b0001 << mon_e.ch)) begin
              errors++;
              $display("FAIL frame_cs: got %b want %b", fr_cs, ~(4'b0001 << mon_e.ch));
            end
            if (word !== mon_e.data) begin
              errors++;
              $display("FAIL frame_data: got %h want %h", word, mon_e.data);
            end
            if (nbits != 8 || low_cnt != 32) begin
              errors++;
              $display("FAIL frame_shape: got %0d edges %0d low cycles want 8 and 32", nbits, low_cnt);
            end
            if (ifa.ch_sel !== mon_e.ch) begin
              errors++;
              $display("FAIL frame_ch_sel: got %0d want %0d", ifa.ch_sel, mon_e.ch);
            end
          end
        end else begin
          low_cnt++;
          if (ifa.sclk && !prev_sclk) begin
            word = {word[6:0], ifa.mosi};
            nbits++;
          end
        end
      end else gap_cnt++;
      prev_sclk = ifa.sclk;
    end
  end
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic push_exp(input logic [1:0] ch, input logic [7:0] data);
    exp_t e;
    e.ch   = ch;
    e.data = data;
    sb.push_back(e);
  endtask
  task automatic wait_frames(input int target, input string name);
    int n = 0;
    while (frames < target && n < 3000) begin
      tick;
      n++;
    end
    checks++;
    if (frames != target) begin
      errors++;
      $display("FAIL %s_frames: got %0d frames want %0d", name, frames, target);
    end
  endtask
  task automatic wait_rens(input int target, input string name);
    int n = 0;
    while (ren_cnt < target && n < 3000) begin
      tick;
      n++;
    end
    checks++;
    if (ren_cnt != target) begin
      errors++;
      $display("FAIL %s_ren: got %0d pops want %0d", name, ren_cnt, target);
    end
  endtask
  task automatic test_reset;
    rstn = 1'b0;
    ifa.enable = 0; ifa.not_empty = '0;
    ifa.rdata0 = '0; ifa.rdata1 = '0; ifa.rdata2 = '0; ifa.rdata3 = '0;
    ifb.enable = 0; ifb.not_empty = '0;
    ifb.rdata0 = '0; ifb.rdata1 = '0; ifb.rdata2 = '0; ifb.rdata3 = '0;
    repeat (3) tick;
    checks += 4;
    if (ifa.ren !== 4'h0 || ifa.cs_n !== 4'hF) begin
      errors++;
      $display("FAIL reset_ren_cs: got ren=%b cs_n=%b want 0000 1111", ifa.ren, ifa.cs_n);
    end
    if (ifa.sclk !== 1'b0 || ifa.mosi !== 1'b0) begin
      errors++;
      $display("FAIL reset_sclk_mosi: got %b %b want 0 0", ifa.sclk, ifa.mosi);
    end
    if (ifa.busy !== 1'b0 || ifa.ch_sel !== 2'd0) begin
      errors++;
      $display("FAIL reset_busy_chsel: got %b %0d want 0 0", ifa.busy, ifa.ch_sel);
    end
    if (ifb.cs_n !== 4'hF || ifb.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_div1: got cs_n=%b busy=%b want 1111 0", ifb.cs_n, ifb.busy);
    end
    rstn = 1'b1;
    repeat (2) tick;
  endtask
  task automatic test_round_robin;
    logic [7:0] d [4];
    int base = ren_cnt;
    int fb = frames;
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
    ifa.rdata0 = d[0]; ifa.rdata1 = d[1]; ifa.rdata2 = d[2]; ifa.rdata3 = d[3];
    gaps.delete();
    for (int i = 0; i < 5; i++) push_exp(2'(i % 4), d[i % 4]);
    ifa.enable = 1;
    ifa.not_empty = 4'hF;
    wait_rens(base + 5, "rr");
    ifa.not_empty = 4'h0;
    wait_frames(fb + 5, "rr");
    checks++;
    if (gaps.size() != 4) begin
      errors++;
      $display("FAIL rr_gap_count: got %0d gaps want 4", gaps.size());
    end
    foreach (gaps[i]) begin
      checks++;
      if (gaps[i] != 5) begin
        errors++;
        $display("FAIL rr_gap: got %0d cycles cs_n high want 5", gaps[i]);
      end
    end
    repeat (6) tick;
  endtask
  task automatic test_skip_empty;
    int base = ren_cnt;
    int fb = frames;
    ifa.rdata1 = 8'h5A;
    ifa.rdata3 = 8'h3C;
    push_exp(2'd1, 8'h5A);
    push_exp(2'd3, 8'h3C);
    push_exp(2'd1, 8'h5A);
    ren_hist = '0;
    ifa.not_empty = 4'b1010;
    wait_rens(base + 3, "skip");
    ifa.not_empty = 4'h0;
    wait_frames(fb + 3, "skip");
    checks++;
    if (ren_hist !== 4'b1010) begin
      errors++;
      $display("FAIL skip_ren_hist: got %b want 1010", ren_hist);
    end
    repeat (6) tick;
  endtask
  task automatic test_single_frame;
    int base = ren_cnt;
    int fb = frames;
    ifa.rdata2 = 8'hA5;
    push_exp(2'd2, 8'hA5);
    ifa.not_empty = 4'b0100;
    tick;
    tick;
    checks++;
    if (ifa.ren !== 4'b0100) begin
      errors++;
      $display("FAIL single_ren: got %b want 0100", ifa.ren);
    end
    ifa.not_empty = 4'h0;
    tick;
    checks++;
    if (ifa.cs_n !== 4'hF || ifa.ren !== 4'h0) begin
      errors++;
      $display("FAIL single_load: got cs_n=%b ren=%b want 1111 0000", ifa.cs_n, ifa.ren);
    end
    tick;
    checks++;
    if (ifa.cs_n !== 4'b1011) begin
      errors++;
      $display("FAIL single_latency: got cs_n=%b want 1011", ifa.cs_n);
    end
    wait_frames(fb + 1, "single");
    checks++;
    if (ifa.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_gap0: got %b want 1", ifa.busy);
    end
    tick;
    checks++;
    if (ifa.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_gap1: got %b want 1", ifa.busy);
    end
    tick;
    checks += 2;
    if (ifa.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_idle: got %b want 0", ifa.busy);
    end
    if (ifa.ch_sel !== 2'd2 || ren_cnt != base + 1) begin
      errors++;
      $display("FAIL single_hold: got ch_sel=%0d pops=%0d want 2 %0d", ifa.ch_sel, ren_cnt - base, 1);
    end
    repeat (4) tick;
  endtask
  task automatic test_enable_drop;
    int base = ren_cnt;
    int fb = frames;
    int rises = 0;
    int n = 0;
    logic prev = 1'b0;
    ifa.rdata0 = 8'hC3;
    push_exp(2'd0, 8'hC3);
    ifa.not_empty = 4'b0001;
    while (rises < 3 && n < 500) begin
      tick;
      n++;
      if (ifa.sclk && !prev) rises++;
      prev = ifa.sclk;
    end
    ifa.enable = 0;
    checks++;
    if (rises != 3) begin
      errors++;
      $display("FAIL drop_rises: got %0d rising edges want 3", rises);
    end
    wait_frames(fb + 1, "drop");
    repeat (20) tick;
    checks += 2;
    if (ren_cnt != base + 1) begin
      errors++;
      $display("FAIL drop_no_pop: got %0d pops want 1", ren_cnt - base);
    end
    if (ifa.busy !== 1'b0 || ifa.cs_n !== 4'hF) begin
      errors++;
      $display("FAIL drop_idle: got busy=%b cs_n=%b want 0 1111", ifa.busy, ifa.cs_n);
    end
    ifa.not_empty = 4'h0;
  endtask
  task automatic test_reset_mid;
    int rises = 0;
    int n = 0;
    int fb;
    logic prev = 1'b0;
    ifa.rdata0 = 8'h0F;
    ifa.rdata1 = 8'h77;
    ifa.enable = 1;
    ifa.not_empty = 4'b0001;
    while (rises < 5 && n < 500) begin
      tick;
      n++;
      if (ifa.sclk && !prev) rises++;
      prev = ifa.sclk;
    end
    checks++;
    if (rises != 5 || ifa.mosi !== 1'b1 || ifa.cs_n !== 4'b1110) begin
      errors++;
      $display("FAIL mid_setup: got rises=%0d mosi=%b cs_n=%b want 5 1 1110", rises, ifa.mosi, ifa.cs_n);
    end
    rstn = 1'b0;
    #1;
    checks += 2;
    if (ifa.cs_n !== 4'hF || ifa.sclk !== 1'b0 || ifa.mosi !== 1'b0) begin
      errors++;
      $display("FAIL mid_async: got cs_n=%b sclk=%b mosi=%b want 1111 0 0", ifa.cs_n, ifa.sclk, ifa.mosi);
    end
    if (ifa.busy !== 1'b0 || ifa.ren !== 4'h0) begin
      errors++;
      $display("FAIL mid_async_busy: got busy=%b ren=%b want 0 0000", ifa.busy, ifa.ren);
    end
    repeat (3) tick;
    ifa.not_empty = 4'b0011;
    push_exp(2'd0, 8'h0F);
    fb = frames;
    rstn = 1'b1;
    wait_rens(ren_cnt + 1, "mid");
    ifa.not_empty = 4'h0;
    wait_frames(fb + 1, "mid");
    repeat (6) tick;
    ifa.enable = 0;
  endtask
  task automatic test_div1;
    int n = 0;
    int cnt = 0;
    int bad = 0;
    logic prev = 1'b0;
    logic [7:0] w = '0;
    ifb.rdata0 = 8'h96;
    ifb.enable = 1;
    ifb.not_empty = 4'b0001;
    while (ifb.cs_n == 4'hF && n < 100) begin
      tick;
      n++;
      if (|ifb.ren) ifb.not_empty = 4'h0;
    end
    checks++;
    if (ifb.cs_n !== 4'b1110) begin
      errors++;
      $display("FAIL div1_start: got cs_n=%b want 1110", ifb.cs_n);
    end
    while (ifb.cs_n != 4'hF && cnt < 100) begin
      cnt++;
      if (ifb.sclk && !prev) w = {w[6:0], ifb.mosi};
      if (cnt > 1 && ifb.sclk == prev) bad++;
      prev = ifb.sclk;
      tick;
    end
    checks += 3;
    if (cnt != 16) begin
      errors++;
      $display("FAIL div1_low: got %0d cycles want 16", cnt);
    end
    if (bad != 0) begin
      errors++;
      $display("FAIL div1_toggle: got %0d non-toggling cycles want 0", bad);
    end
    if (w !== 8'h96 || ifb.ch_sel !== 2'd0) begin
      errors++;
      $display("FAIL div1_data: got %h ch %0d want 96 ch 0", w, ifb.ch_sel);
    end
    ifb.enable = 0;
    repeat (5) tick;
  endtask
  initial begin
    test_reset;
    test_round_robin;
    test_skip_empty;
    test_single_frame;
    test_enable_drop;
    test_reset_mid;
    test_div1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d frames outstanding want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
